// File: rtl/drive_cmd_sequencer.sv
// Drive command sequencer: arbitrates manual/autonomous commands and applies them
// on PWM frame boundaries, with reversal dwell, watchdog and e-stop handling.
module drive_cmd_sequencer #(
    parameter int unsigned REV_DWELL_FRAMES = 10,
    parameter int unsigned WDOG_FRAMES      = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       estop,
    input  logic       btn_valid,
    input  logic [1:0] btn_dir,
    input  logic [1:0] btn_thr,
    input  logic       auto_enable,
    input  logic       auto_valid,
    input  logic [1:0] auto_dir,
    input  logic [1:0] auto_thr,
    output logic [1:0] direction,
    output logic [1:0] throttle,
    output logic [1:0] thr_state,
    output logic       src_auto,
    output logic       wdog_expired
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_FWD     = 2'd1,
        ST_REV     = 2'd2,
        ST_DWELL   = 2'd3
    } thrState_t;

    localparam logic [1:0] THR_REV  = 2'd1;
    localparam logic [1:0] THR_FWD  = 2'd2;
    localparam logic [1:0] THR_STOP = 2'd3;
    localparam logic [1:0] DIR_NEUTRAL = 2'd3;

    localparam logic [7:0] LP_DWELL_LAST = 8'(REV_DWELL_FRAMES - 1);
    localparam logic [7:0] LP_WDOG_LAST  = 8'(WDOG_FRAMES - 1);
    localparam logic [7:0] LP_WDOG_FULL  = 8'(WDOG_FRAMES);

    thrState_t  r_state;
    logic [7:0] r_dwellCnt;
    logic       r_dwellToRev;
    logic [1:0] r_direction;
    logic [1:0] r_throttle;
    logic       r_srcAuto;
    logic [7:0] r_wdogCnt;
    logic       r_wdogExpired;
    logic [1:0] r_pendDir;
    logic [1:0] r_pendThr;
    logic       r_pendValid;
    logic       r_pendAuto;

    logic       w_accBtn;
    logic       w_accAuto;
    logic       w_accept;
    logic [1:0] w_cmdDir;
    logic [1:0] w_cmdThr;
    logic [1:0] w_mergedDir;
    logic [1:0] w_mergedThr;
    logic       w_mergedValid;
    logic       w_mergedAuto;
    logic       w_wdogFire;
    thrState_t  w_nextState;
    logic [7:0] w_nextCnt;
    logic       w_nextToRev;

    function automatic logic [1:0] thrCode(input thrState_t s);
        case (s)
            ST_FWD:  thrCode = THR_FWD;
            ST_REV:  thrCode = THR_REV;
            default: thrCode = THR_STOP;
        endcase
    endfunction

    // A command accepted in the tick cycle is merged into what that tick applies.
    assign w_accBtn      = btn_valid & ~estop;
    assign w_accAuto     = auto_valid & auto_enable & ~btn_valid & ~estop;
    assign w_accept      = w_accBtn | w_accAuto;
    assign w_cmdDir      = w_accBtn ? btn_dir : auto_dir;
    assign w_cmdThr      = w_accBtn ? btn_thr : auto_thr;
    assign w_mergedDir   = (w_accept && (w_cmdDir != 2'd0)) ? w_cmdDir : r_pendDir;
    assign w_mergedThr   = (w_accept && (w_cmdThr != 2'd0)) ? w_cmdThr : r_pendThr;
    assign w_mergedValid = w_accept | r_pendValid;
    assign w_mergedAuto  = w_accept ? w_accAuto : r_pendAuto;
    assign w_wdogFire    = frame_tick & ~w_accept & (r_wdogCnt == LP_WDOG_LAST);

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_dwellCnt;
        w_nextToRev = r_dwellToRev;
        if (estop || w_wdogFire) begin
            w_nextState = ST_STOPPED;
            w_nextCnt   = 8'd0;
        end else if (frame_tick) begin
            case (r_state)
                ST_STOPPED: begin
                    if (w_mergedThr == THR_FWD)      w_nextState = ST_FWD;
                    else if (w_mergedThr == THR_REV) w_nextState = ST_REV;
                end
                ST_FWD: begin
                    if (w_mergedThr == THR_STOP) begin
                        w_nextState = ST_STOPPED;
                    end else if (w_mergedThr == THR_REV) begin
                        w_nextState = ST_DWELL;
                        w_nextCnt   = 8'd0;
                        w_nextToRev = 1'b1;
                    end
                end
                ST_REV: begin
                    if (w_mergedThr == THR_STOP) begin
                        w_nextState = ST_STOPPED;
                    end else if (w_mergedThr == THR_FWD) begin
                        w_nextState = ST_DWELL;
                        w_nextCnt   = 8'd0;
                        w_nextToRev = 1'b0;
                    end
                end
                default: begin
                    // Asking for the direction we came from aborts the reversal.
                    if (w_mergedThr == THR_STOP) begin
                        w_nextState = ST_STOPPED;
                        w_nextCnt   = 8'd0;
                    end else if (w_mergedThr == (r_dwellToRev ? THR_FWD : THR_REV)) begin
                        w_nextState = r_dwellToRev ? ST_FWD : ST_REV;
                        w_nextCnt   = 8'd0;
                    end else if (r_dwellCnt == LP_DWELL_LAST) begin
                        w_nextState = r_dwellToRev ? ST_REV : ST_FWD;
                        w_nextCnt   = 8'd0;
                    end else begin
                        w_nextCnt = r_dwellCnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_STOPPED;
            r_dwellCnt    <= 8'd0;
            r_dwellToRev  <= 1'b0;
            r_direction   <= DIR_NEUTRAL;
            r_throttle    <= THR_STOP;
            r_srcAuto     <= 1'b0;
            r_wdogCnt     <= 8'd0;
            r_wdogExpired <= 1'b0;
            r_pendDir     <= 2'd0;
            r_pendThr     <= 2'd0;
            r_pendValid   <= 1'b0;
            r_pendAuto    <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_dwellCnt   <= w_nextCnt;
            r_dwellToRev <= w_nextToRev;
            r_throttle   <= thrCode(w_nextState);

            if (estop) begin
                r_direction <= DIR_NEUTRAL;
                r_pendDir   <= 2'd0;
                r_pendThr   <= 2'd0;
                r_pendValid <= 1'b0;
                r_pendAuto  <= 1'b0;
            end else if (frame_tick) begin
                if (w_mergedDir != 2'd0) r_direction <= w_mergedDir;
                if (w_mergedValid)       r_srcAuto   <= w_mergedAuto;
                r_pendDir   <= 2'd0;
                r_pendThr   <= 2'd0;
                r_pendValid <= 1'b0;
                r_pendAuto  <= 1'b0;
            end else if (w_accept) begin
                r_pendDir   <= w_mergedDir;
                r_pendThr   <= w_mergedThr;
                r_pendValid <= 1'b1;
                r_pendAuto  <= w_accAuto;
            end

            // Watchdog counter saturates so it fires exactly once per silence.
            if (w_accept) begin
                r_wdogCnt     <= 8'd0;
                r_wdogExpired <= 1'b0;
            end else if (frame_tick && (r_wdogCnt != LP_WDOG_FULL)) begin
                r_wdogCnt <= r_wdogCnt + 8'd1;
                if (w_wdogFire) r_wdogExpired <= 1'b1;
            end
        end
    end

    assign direction    = r_direction;
    assign throttle     = r_throttle;
    assign thr_state    = r_state;
    assign src_auto     = r_srcAuto;
    assign wdog_expired = r_wdogExpired;

endmodule

// File: tb/tb_drive_cmd_sequencer.sv
// Testbench for drive_cmd_sequencer: table of per-cycle vectors plus hand-written
// dwell, watchdog, e-stop and reset sequences, checked through an expectation queue.
module tb_drive_cmd_sequencer;

    localparam int unsigned DWELL = 10;
    localparam int unsigned WDOG  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       estop;
    logic       btn_valid;
    logic [1:0] btn_dir;
    logic [1:0] btn_thr;
    logic       auto_enable;
    logic       auto_valid;
    logic [1:0] auto_dir;
    logic [1:0] auto_thr;
    logic [1:0] direction;
    logic [1:0] throttle;
    logic [1:0] thr_state;
    logic       src_auto;
    logic       wdog_expired;

    always #5 clk = ~clk;

    drive_cmd_sequencer #(
        .REV_DWELL_FRAMES(DWELL),
        .WDOG_FRAMES     (WDOG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .estop       (estop),
        .btn_valid   (btn_valid),
        .btn_dir     (btn_dir),
        .btn_thr     (btn_thr),
        .auto_enable (auto_enable),
        .auto_valid  (auto_valid),
        .auto_dir    (auto_dir),
        .auto_thr    (auto_thr),
        .direction   (direction),
        .throttle    (throttle),
        .thr_state   (thr_state),
        .src_auto    (src_auto),
        .wdog_expired(wdog_expired)
    );

    typedef struct {
        string      name;
        logic       r;
        logic       tick;
        logic       es;
        logic       bv;
        logic [1:0] bd;
        logic [1:0] bt;
        logic       ae;
        logic       av;
        logic [1:0] ad;
        logic [1:0] at;
        logic [1:0] eDir;
        logic [1:0] eThr;
        logic [1:0] eSt;
        logic       eSrc;
        logic       eWd;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] want;
    } exp_t;

    exp_t expQ[$];
    vec_t table_[$];
    int   nVectors     = 0;
    int   nMiscompares = 0;

    function automatic vec_t mk(input string name, input logic r, input logic tick, input logic es,
                                input logic bv, input logic [1:0] bd, input logic [1:0] bt,
                                input logic ae, input logic av, input logic [1:0] ad, input logic [1:0] at,
                                input logic [1:0] eDir, input logic [1:0] eThr, input logic [1:0] eSt,
                                input logic eSrc, input logic eWd);
        vec_t v;
        v.name = name; v.r = r; v.tick = tick; v.es = es;
        v.bv = bv; v.bd = bd; v.bt = bt;
        v.ae = ae; v.av = av; v.ad = ad; v.at = at;
        v.eDir = eDir; v.eThr = eThr; v.eSt = eSt; v.eSrc = eSrc; v.eWd = eWd;
        return v;
    endfunction

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] got;
        if (expQ.size() == 0) return;
        e   = expQ.pop_front();
        got = {direction, throttle, thr_state, src_auto, wdog_expired};
        nVectors++;
        if (got !== e.want) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got dir=%0d thr=%0d st=%0d src=%0d wd=%0d, expected dir=%0d thr=%0d st=%0d src=%0d wd=%0d",
                     e.name, got[7:6], got[5:4], got[3:2], got[1], got[0],
                     e.want[7:6], e.want[5:4], e.want[3:2], e.want[1], e.want[0]);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst = v.r; frame_tick = v.tick; estop = v.es;
        btn_valid = v.bv; btn_dir = v.bd; btn_thr = v.bt;
        auto_enable = v.ae; auto_valid = v.av; auto_dir = v.ad; auto_thr = v.at;
        e.name = v.name;
        e.want = {v.eDir, v.eThr, v.eSt, v.eSrc, v.eWd};
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        // name, rst, tick, estop, bv, bd, bt, ae, av, ad, at | dir, thr, st, src, wd
        table_.push_back(mk("reset",          1,0,0, 0,0,0, 0,0,0,0, 3,3,0,0,0));
        table_.push_back(mk("pend_no_tick",   0,0,0, 1,1,2, 0,0,0,0, 3,3,0,0,0));
        table_.push_back(mk("fwd_apply",      0,1,0, 0,0,0, 0,0,0,0, 1,2,1,0,0));
        table_.push_back(mk("arb_hold",       0,0,0, 1,0,3, 1,1,2,2, 1,2,1,0,0));
        table_.push_back(mk("btn_wins",       0,1,0, 0,0,0, 1,0,0,0, 1,3,0,0,0));
        table_.push_back(mk("auto_same_tick", 0,1,0, 0,0,0, 1,1,2,2, 2,2,1,1,0));
        table_.push_back(mk("auto_dis_hold",  0,0,0, 0,0,0, 0,1,1,3, 2,2,1,1,0));
        table_.push_back(mk("auto_dis_tick",  0,1,0, 0,0,0, 0,1,1,3, 2,2,1,1,0));
        table_.push_back(mk("dir0_holds",     0,1,0, 1,0,2, 0,0,0,0, 2,2,1,0,0));
        table_.push_back(mk("merge_a",        0,0,0, 1,1,0, 0,0,0,0, 2,2,1,0,0));
        table_.push_back(mk("merge_b",        0,0,0, 1,0,2, 0,0,0,0, 2,2,1,0,0));
        table_.push_back(mk("merge_apply",    0,1,0, 0,0,0, 0,0,0,0, 1,2,1,0,0));
        table_.push_back(mk("enter_dwell",    0,1,0, 1,0,1, 0,0,0,0, 1,3,3,0,0));

        foreach (table_[i]) applyStimulus(table_[i]);

        // Reversal dwell; a repeated reverse request mid-dwell must not restart the count.
        for (int k = 1; k <= int'(DWELL); k++) begin
            if (k < int'(DWELL))
                applyStimulus(mk($sformatf("dwell_%0d", k), 0,1,0, (k == 5),0,1, 0,0,0,0, 1,3,3,0,0));
            else
                applyStimulus(mk("dwell_done",             0,1,0, 0,0,0,      0,0,0,0, 1,1,2,0,0));
        end
        applyStimulus(mk("rev_to_dwell",  0,1,0, 1,0,2, 0,0,0,0, 1,3,3,0,0));
        applyStimulus(mk("dwell_cancel",  0,1,0, 1,0,1, 0,0,0,0, 1,1,2,0,0));
        applyStimulus(mk("rev_stop",      0,1,0, 1,0,3, 0,0,0,0, 1,3,0,0,0));

        // Watchdog: silence for WDOG ticks after the last accept.
        applyStimulus(mk("wd_start",      0,1,0, 1,2,2, 0,0,0,0, 2,2,1,0,0));
        for (int k = 1; k <= int'(WDOG); k++) begin
            if (k < int'(WDOG))
                applyStimulus(mk($sformatf("wd_tick_%0d", k), 0,1,0, 0,0,0, 0,0,0,0, 2,2,1,0,0));
            else
                applyStimulus(mk("wd_fire",                   0,1,0, 0,0,0, 0,0,0,0, 2,3,0,0,1));
        end
        applyStimulus(mk("wd_sat",        0,1,0, 0,0,0, 0,0,0,0, 2,3,0,0,1));
        applyStimulus(mk("wd_clear",      0,0,0, 1,0,0, 0,0,0,0, 2,3,0,0,0));

        // E-stop mid-dwell with a forward request still pending.
        applyStimulus(mk("es_fwd",        0,1,0, 1,0,2, 0,0,0,0, 2,2,1,0,0));
        applyStimulus(mk("es_dwell",      0,1,0, 1,0,1, 0,0,0,0, 2,3,3,0,0));
        applyStimulus(mk("es_pend",       0,0,0, 1,0,2, 0,0,0,0, 2,3,3,0,0));
        applyStimulus(mk("es_assert",     0,0,1, 0,0,0, 0,0,0,0, 3,3,0,0,0));
        applyStimulus(mk("es_ignore_acc", 0,1,1, 1,1,2, 0,0,0,0, 3,3,0,0,0));
        applyStimulus(mk("es_release_1",  0,1,0, 0,0,0, 0,0,0,0, 3,3,0,0,0));
        applyStimulus(mk("es_release_2",  0,1,0, 0,0,0, 0,0,0,0, 3,3,0,0,0));
        applyStimulus(mk("es_resume",     0,1,0, 1,0,2, 0,0,0,0, 3,2,1,0,0));

        // Reset while running under autonomous control.
        applyStimulus(mk("auto_run",      0,1,0, 0,0,0, 1,1,1,2, 1,2,1,1,0));
        applyStimulus(mk("mid_reset",     1,1,0, 1,2,1, 0,0,0,0, 3,3,0,0,0));
        applyStimulus(mk("post_reset",    0,1,0, 0,0,0, 0,0,0,0, 3,3,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
